// File: rtl/assoc_dcache.sv
// rtl/assoc_dcache.sv - set-associative write-back, write-allocate data cache
module assoc_dcache #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int IDX = $clog2(SETS);
    localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW  = 28 - IDX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, MEM_READ, FILL} state_t;

    state_t          state_q, state_d;
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] valid_d [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-1:0] dirty_d [SETS];
    logic [AW-1:0]   age_q   [SETS][WAYS];
    logic [AW-1:0]   age_d   [SETS][WAYS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [TW-1:0]   tag_d   [SETS][WAYS];
    logic [127:0]    data_q  [SETS][WAYS];
    logic [127:0]    data_d  [SETS][WAYS];
    logic [AW-1:0]   victim_q, victim_d;
    logic [127:0]    fill_q, fill_d;
    logic [31:0]     hit_count_q, hit_count_d;
    logic [31:0]     miss_count_q, miss_count_d;

    logic [IDX-1:0]  idx;
    logic [1:0]      word;
    logic [TW-1:0]   tag;
    logic            req, hit_any, hit, found_free, touch, fill_into_empty;
    logic [AW-1:0]   hit_way, vic_way, acc_way, old_age, max_age;
    logic [127:0]    line;
    logic            unused_addr_bits;

    assign idx              = address[IDX+3:4];
    assign word             = address[3:2];
    assign tag              = address[31:IDX+4];
    assign req              = read | write;
    assign unused_addr_bits = ^address[1:0];

    // Hit detection and victim choice: first free way, else oldest (lowest index on ties).
    always_comb begin
        hit_any    = 1'b0;
        hit_way    = '0;
        found_free = 1'b0;
        vic_way    = '0;
        max_age    = age_q[idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = AW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                found_free = 1'b1;
                vic_way    = AW'(w);
            end
        end
        if (!found_free) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[idx][w] > max_age) begin
                    max_age = age_q[idx][w];
                    vic_way = AW'(w);
                end
            end
        end
    end

    assign hit = req && hit_any;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        age_d           = age_q;
        tag_d           = tag_q;
        data_d          = data_q;
        victim_d        = victim_q;
        fill_d          = fill_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        line            = fill_q;
        old_age         = '0;
        touch           = 1'b0;
        acc_way         = victim_q;
        fill_into_empty = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    touch   = 1'b1;
                    acc_way = hit_way;
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
                    if (write) begin
                        data_d[idx][hit_way][{word, 5'b0} +: 32] = writedata;
                        dirty_d[idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
                    victim_d = vic_way;
                    state_d  = (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) ? WRITEBACK : MEM_READ;
                end
            end
            WRITEBACK: if (!mem_busywait) state_d = MEM_READ;
            MEM_READ: begin
                if (!mem_busywait) begin
                    fill_d  = mem_readdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                touch           = 1'b1;
                fill_into_empty = !valid_q[idx][victim_q];
                if (write) line[{word, 5'b0} +: 32] = writedata;
                data_d[idx][victim_q]  = line;
                tag_d[idx][victim_q]   = tag;
                valid_d[idx][victim_q] = 1'b1;
                dirty_d[idx][victim_q] = write;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A fill into a free way ages every resident line, since the new line has no prior age.
        if (touch) begin
            old_age = age_q[idx][acc_way];
            for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == acc_way)
                    age_d[idx][w] = '0;
                else if (valid_q[idx][w] && (fill_into_empty || age_q[idx][w] < old_age))
                    age_d[idx][w] = age_q[idx][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            age_q        <= age_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q    <= tag_d;
        data_q   <= data_d;
        victim_q <= victim_d;
        fill_q   <= fill_d;
    end

    always_comb begin
        readdata      = hit ? data_q[idx][hit_way][{word, 5'b0} +: 32] : 32'h0;
        mem_writedata = data_q[idx][victim_q];
        mem_address   = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx} : address[31:4];
        mem_read      = !reset && state_q == MEM_READ;
        mem_write     = !reset && state_q == WRITEBACK;
        busywait      = !reset && ((state_q == IDLE) ? (req && !hit) : 1'b1);
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_assoc_dcache.sv
// tb/tb_assoc_dcache.sv - directed self-checking bench for assoc_dcache
module tb_assoc_dcache;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  address = '0;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b1;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    assoc_dcache #(.SETS(8), .WAYS(2)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mw(input logic [27:0] a, input int i);
        logic [7:0] lo;
        lo = i[7:0];
        return {4'hA, a[19:0], lo};
    endfunction

    function automatic logic [127:0] blk(input logic [27:0] a);
        return {mw(a, 3), mw(a, 2), mw(a, 1), mw(a, 0)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic chka(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    task automatic apply(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        read = rd; write = wr; address = addr; writedata = data;
        #1;
    endtask

    task automatic finish_access();
        @(posedge clock);
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        #1;
    endtask

    task automatic hit_access(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_rd);
        apply(rd, wr, addr, data);
        chkb({tag, " busywait"}, busywait, 1'b0);
        chkb({tag, " no traffic"}, mem_read | mem_write, 1'b0);
        if (!wr) chkw({tag, " readdata"}, readdata, exp_rd);
        finish_access();
    endtask

    // Entered at a negedge with the missing request applied and settled.
    task automatic serve_miss(input string tag, input bit wb, input logic [27:0] wb_addr,
                              input logic [127:0] wb_data, input logic [27:0] rd_addr);
        chkb({tag, " miss busywait"}, busywait, 1'b1);
        chkw({tag, " miss readdata"}, readdata, 32'h0);
        @(posedge clock); @(negedge clock);
        if (wb) begin
            chkb({tag, " wb mem_write"}, mem_write, 1'b1);
            chkb({tag, " wb mem_read"}, mem_read, 1'b0);
            chka({tag, " wb address"}, mem_address, wb_addr);
            chk({tag, " wb data"}, mem_writedata, wb_data);
            mem_busywait = 1'b0;
            @(posedge clock); @(negedge clock);
            mem_busywait = 1'b1;
        end else begin
            chkb({tag, " no wb"}, mem_write, 1'b0);
        end
        chkb({tag, " mem_read"}, mem_read, 1'b1);
        chka({tag, " rd address"}, mem_address, rd_addr);
        @(posedge clock); @(negedge clock);
        chkb({tag, " mem_read held"}, mem_read, 1'b1);
        mem_readdata = blk(rd_addr);
        mem_busywait = 1'b0;
        @(posedge clock); @(negedge clock);
        mem_busywait = 1'b1;
        chkb({tag, " fill busywait"}, busywait, 1'b1);
        chkb({tag, " fill quiet"}, mem_read | mem_write, 1'b0);
        @(posedge clock); @(negedge clock);
        #1;
        chkb({tag, " done busywait"}, busywait, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chkb("reset busywait", busywait, 1'b0);
        chkb("reset mem_read", mem_read, 1'b0);
        reset = 1'b0;
        #1;
        chkw("reset readdata", readdata, 32'h0);
        chkw("reset hits", hit_count, 32'h0);
        chkw("reset misses", miss_count, 32'h0);

        apply(1'b1, 1'b0, 32'h010, 32'h0);
        chkb("ld010 mem idle", mem_read, 1'b0);
        serve_miss("ld010", 1'b0, 28'h0, 128'h0, 28'h0000001);
        chkw("ld010 readdata", readdata, mw(28'h1, 0));
        finish_access();
        chkw("ld010 hits", hit_count, 32'd1);
        chkw("ld010 misses", miss_count, 32'd1);

        hit_access("st014", 1'b0, 1'b1, 32'h014, 32'hDEADBEEF, 32'h0);
        chkw("st014 hits", hit_count, 32'd2);
        hit_access("ld014", 1'b1, 1'b0, 32'h014, 32'h0, 32'hDEADBEEF);
        chkw("ld014 hits", hit_count, 32'd3);

        apply(1'b1, 1'b0, 32'h090, 32'h0);
        serve_miss("ld090", 1'b0, 28'h0, 128'h0, 28'h0000009);
        chkw("ld090 readdata", readdata, mw(28'h9, 0));
        finish_access();
        hit_access("ld010 again", 1'b1, 1'b0, 32'h010, 32'h0, mw(28'h1, 0));

        apply(1'b1, 1'b0, 32'h110, 32'h0);
        serve_miss("ld110", 1'b0, 28'h0, 128'h0, 28'h0000011);
        chkw("ld110 readdata", readdata, mw(28'h11, 0));
        finish_access();

        apply(1'b1, 1'b0, 32'h090, 32'h0);
        serve_miss("ld090 evict dirty", 1'b1, 28'h0000001,
                   {mw(28'h1, 3), mw(28'h1, 2), 32'hDEADBEEF, mw(28'h1, 0)}, 28'h0000009);
        finish_access();

        apply(1'b0, 1'b1, 32'h208, 32'h12345678);
        serve_miss("st208", 1'b0, 28'h0, 128'h0, 28'h0000020);
        finish_access();
        hit_access("ld208", 1'b1, 1'b0, 32'h208, 32'h0, 32'h12345678);
        hit_access("ld200", 1'b1, 1'b0, 32'h200, 32'h0, mw(28'h20, 0));

        apply(1'b1, 1'b0, 32'h000, 32'h0);
        serve_miss("ld000", 1'b0, 28'h0, 128'h0, 28'h0000000);
        finish_access();
        apply(1'b1, 1'b0, 32'h080, 32'h0);
        serve_miss("ld080 evict 208", 1'b1, 28'h0000020,
                   {mw(28'h20, 3), 32'h12345678, mw(28'h20, 1), mw(28'h20, 0)}, 28'h0000008);
        finish_access();
        chkw("total hits", hit_count, 32'd12);
        chkw("total misses", miss_count, 32'd7);

        apply(1'b1, 1'b0, 32'h310, 32'h0);
        @(posedge clock); @(negedge clock);
        chkb("ld310 mem_read", mem_read, 1'b1);
        chka("ld310 address", mem_address, 28'h0000031);
        reset = 1'b1;
        #1;
        chkb("mid reset mem_read", mem_read, 1'b0);
        chkb("mid reset busywait", busywait, 1'b0);
        chkb("mid reset mem_write", mem_write, 1'b0);
        chkw("mid reset readdata", readdata, 32'h0);
        chkw("mid reset hits", hit_count, 32'h0);
        chkw("mid reset misses", miss_count, 32'h0);
        @(posedge clock); @(negedge clock);
        read = 1'b0;
        reset = 1'b0;

        apply(1'b1, 1'b0, 32'h010, 32'h0);
        serve_miss("post reset ld010", 1'b0, 28'h0, 128'h0, 28'h0000001);
        chkw("post reset readdata", readdata, mw(28'h1, 0));
        finish_access();
        chkw("post reset misses", miss_count, 32'd1);
        chkw("post reset hits", hit_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
